mem_line_server: RTL and testbench
==================================

Name: mem_line_server

Overview:
- Synchronous line-granular main-memory model sitting directly downstream of the cache on the C2 (cache-to-memory) bus.
- Accepts READ_LINE and WRITE_LINE commands and transfers whole cache lines in bus-width beats.
- Models a fixed access latency and returns C2_RESPONSE.
- Bidirectional C2 wires are split into in/out/output-enable ports; a thin tristate wrapper connects them to the shared nets.

Parameters:
- ADDR_W, 14, line address width in bits (tag + set bits of the byte address).
- LINE_BYTES, 16, bytes per cache line.
- BUS_BYTES, 2, bytes per data beat; LINE_BYTES must be a multiple of BUS_BYTES.
- MEM_LINES, 256, number of stored lines, power of two, at most 2**ADDR_W.
- LATENCY, 100, access latency in clk cycles, at least 1.

Ports:
- clk  input  1  rising-edge clock; all sampling and driving on posedge.
- reset  input  1  asynchronous, active-low reset.
- addr_in  input  ADDR_W  line address from the cache, sampled with the command.
- cmd_in  input  2  C2 command from the cache: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3.
- data_in  input  8*BUS_BYTES  write data beat from the cache.
- cmd_out  output  2  C2 command driven by this block (NOP or RESPONSE).
- cmd_oe  output  1  high while this block owns the cmd wires.
- data_out  output  8*BUS_BYTES  read data beat.
- data_oe  output  1  high while this block owns the data wires.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Definitions:
  - BEATS = LINE_BYTES/BUS_BYTES.
  - Beat i carries line bytes [i*BUS_BYTES +: BUS_BYTES] (little-endian, beat 0 first).
  - Storage index = addr_in mod MEM_LINES (low bits; upper bits ignored, wrap-around).
  - Storage is not cleared by reset.
- Reset:
  - Asynchronous on reset low; takes effect immediately and holds while low.
  - Outputs: cmd_out=NOP, cmd_oe=0, data_out=0, data_oe=0, busy=0; state=IDLE; counters=0.
  - Reset mid-transaction aborts it.
  - An aborted write leaves the target line either fully old or fully new, never partial: the line is written only on the last beat.
- Internal state: beat counter (width clog2(BEATS)+1), latency counter (width clog2(LATENCY)+1), beat buffer, latched index.
- States: IDLE, WR_BEATS, WR_WAIT, WR_ACK, RD_WAIT, RD_BEATS.
- IDLE:
  - cmd_in sampled every edge.
  - NOP or RESPONSE: no effect.
  - READ_LINE at edge T0: latch index -> RD_WAIT.
  - WRITE_LINE at edge T0: latch index, capture data_in as beat 0 -> WR_BEATS.
  - If BEATS==1, the line is committed at T0 and the next state is WR_WAIT.
- WR_BEATS:
  - Capture data_in as beat i at edge T0+i.
  - At edge T0+BEATS-1, write the assembled line into storage -> WR_WAIT.
  - cmd_in is ignored during beats; the cache holds WRITE_LINE.
- WR_WAIT:
  - Count LATENCY-1 further edges.
  - Then drive cmd_out=RESPONSE, cmd_oe=1 (data_oe stays 0) -> WR_ACK.
  - RESPONSE is sampled by the cache at edge T0+BEATS-1+LATENCY+1.
- WR_ACK: one cycle; next edge sets cmd_out=NOP, cmd_oe=0 -> IDLE.
- RD_WAIT:
  - After edge T0+LATENCY, assert cmd_oe=1, data_oe=1, cmd_out=RESPONSE, data_out=beat 0 -> RD_BEATS.
  - Storage is read at the latched index at that edge; a write-then-read to the same line returns new data.
- RD_BEATS:
  - Beat i is valid for sampling at edge T0+LATENCY+1+i.
  - After the edge following the last beat, drive cmd_out=NOP, cmd_oe=0, data_oe=0, data_out=0 -> IDLE.
  - RESPONSE is held for exactly BEATS cycles.
- New commands:
  - Accepted only in IDLE.
  - Any cmd_in while busy=1 is ignored; no queueing.
  - A command presented on the same edge that returns the block to IDLE is ignored.
  - The earliest accepted command is one edge after busy falls.
- Output enables:
  - cmd_oe and data_oe are never high in IDLE, WR_BEATS or WR_WAIT.
  - This guarantees no bus contention while the cache drives.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset values: reset low at time 0, then high -> cmd_oe=0, data_oe=0, busy=0, cmd_out=NOP; toggling reset low mid-RD_WAIT returns all outputs to these values within the same cycle.
- Write then read, defaults (BEATS=8, LATENCY=100):
  - WRITE_LINE addr 14'h0155 with beats 16'h0011, 16'h2233, ... 16'hEEFF at T0..T0+7.
  - RESPONSE is seen for exactly one cycle at edge T0+108.
  - A subsequent READ_LINE 14'h0155 at T1 returns the identical 8 beats in order at edges T1+101..T1+108; cmd_oe falls after T1+108.
- Address wrap: write line 0xAAAA... at addr 14'h0003, then read addr 14'h0103 (MEM_LINES=256) -> returns 0xAAAA... line.
- Busy ignore: issue READ_LINE, then present WRITE_LINE to a different address during RD_WAIT -> the write is not performed (a later read of that address returns prior contents) and read timing is unchanged.
- Reset mid-write: reset asserted after beat 3 of a write to a line preloaded with all 16'h5555 beats -> a later read returns all 16'h5555 (no partial update).
- Minimal config (LATENCY=1, BEATS=1):
  - READ_LINE at T0 -> RESPONSE+data valid at edge T0+2 for one cycle.
  - WRITE_LINE at T0 -> RESPONSE valid at edge T0+2.

Source files
------------

// File: rtl/mem_line_server.sv
// Line-granular main-memory model on the C2 bus: whole-line reads/writes in bus-width beats
// after a fixed access latency; outputs are registered and commands arriving while busy are dropped.
module mem_line_server #(
  parameter int ADDR_W     = 14,
  parameter int LINE_BYTES = 16,
  parameter int BUS_BYTES  = 2,
  parameter int MEM_LINES  = 256,
  parameter int LATENCY    = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [1:0]               cmd_in,
  input  logic [8*BUS_BYTES-1:0]   data_in,
  output logic [1:0]               cmd_out,
  output logic                     cmd_oe,
  output logic [8*BUS_BYTES-1:0]   data_out,
  output logic                     data_oe,
  output logic                     busy
);

  localparam int BUS_W = 8 * BUS_BYTES;
  localparam int BEATS = LINE_BYTES / BUS_BYTES;
  localparam int BCW   = $clog2(BEATS) + 1;
  localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LCW   = $clog2(LATENCY) + 1;
  localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
  localparam logic [BCW-1:0] BEAT_END  = BCW'(BEATS);
  localparam logic [BIW-1:0] BEAT0     = '0;
  localparam logic [LCW-1:0] LAT_LAST  = LCW'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BEATS, S_WR_WAIT, S_WR_ACK, S_RD_WAIT, S_RD_BEATS
  } state_t;

  state_t             state, state_d;
  logic [LCW-1:0]     lat_cnt, lat_cnt_d;
  logic [BCW-1:0]     beat_cnt, beat_cnt_d;
  logic [IDX_W-1:0]   idx, idx_d, wr_idx;
  logic [1:0]         cmd_out_d;
  logic               cmd_oe_d, data_oe_d;
  logic [BUS_W-1:0]   data_out_d;
  logic               cap_en, commit;
  logic [BIW-1:0]     cap_idx;

  // Storage and the write assembly buffer deliberately survive reset.
  logic [BUS_W-1:0]   mem      [MEM_LINES][BEATS];
  logic [BUS_W-1:0]   beat_buf [BEATS];

  logic unused_addr;
  assign unused_addr = ^addr_in;

  always_comb begin
    state_d    = state;
    lat_cnt_d  = lat_cnt;
    beat_cnt_d = beat_cnt;
    idx_d      = idx;
    cmd_out_d  = C2_NOP;
    cmd_oe_d   = 1'b0;
    data_out_d = '0;
    data_oe_d  = 1'b0;
    cap_en     = 1'b0;
    commit     = 1'b0;
    cap_idx    = beat_cnt[BIW-1:0];
    wr_idx     = idx;
    case (state)
      S_IDLE: begin
        wr_idx  = addr_in[IDX_W-1:0];
        cap_idx = BEAT0;
        if (cmd_in == C2_READ_LINE) begin
          idx_d     = addr_in[IDX_W-1:0];
          lat_cnt_d = '0;
          state_d   = S_RD_WAIT;
        end else if (cmd_in == C2_WRITE_LINE) begin
          idx_d      = addr_in[IDX_W-1:0];
          lat_cnt_d  = '0;
          beat_cnt_d = BCW'(1);
          cap_en     = 1'b1;
          if (BEATS == 1) begin
            commit  = 1'b1;
            state_d = S_WR_WAIT;
          end else begin
            state_d = S_WR_BEATS;
          end
        end
      end
      S_WR_BEATS: begin
        cap_en     = 1'b1;
        beat_cnt_d = beat_cnt + 1'b1;
        // The line lands in storage only with its final beat, so an abort never tears it.
        if (beat_cnt == BEAT_LAST) begin
          commit  = 1'b1;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          cmd_out_d = C2_RESPONSE;
          cmd_oe_d  = 1'b1;
          state_d   = S_WR_ACK;
        end else begin
          lat_cnt_d = lat_cnt + 1'b1;
        end
      end
      S_WR_ACK: begin
        state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          cmd_out_d  = C2_RESPONSE;
          cmd_oe_d   = 1'b1;
          data_oe_d  = 1'b1;
          data_out_d = mem[idx][BEAT0];
          beat_cnt_d = BCW'(1);
          state_d    = S_RD_BEATS;
        end else begin
          lat_cnt_d = lat_cnt + 1'b1;
        end
      end
      S_RD_BEATS: begin
        if (beat_cnt == BEAT_END) begin
          state_d = S_IDLE;
        end else begin
          cmd_out_d  = C2_RESPONSE;
          cmd_oe_d   = 1'b1;
          data_oe_d  = 1'b1;
          data_out_d = mem[idx][beat_cnt[BIW-1:0]];
          beat_cnt_d = beat_cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      idx      <= '0;
      cmd_out  <= C2_NOP;
      cmd_oe   <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      lat_cnt  <= lat_cnt_d;
      beat_cnt <= beat_cnt_d;
      idx      <= idx_d;
      cmd_out  <= cmd_out_d;
      cmd_oe   <= cmd_oe_d;
      data_out <= data_out_d;
      data_oe  <= data_oe_d;
      busy     <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) beat_buf[cap_idx] <= data_in;
    if (commit && reset) begin
      for (int b = 0; b < BEATS; b++) begin
        mem[wr_idx][b] <= (b == BEATS - 1) ? data_in : beat_buf[b];
      end
    end
  end

endmodule

// File: tb/tb_mem_line_server.sv
// Bench for mem_line_server: default config plus a one-beat, one-cycle-latency instance,
// checked against a line-level reference memory.
module tb_mem_line_server;

  localparam logic [1:0] NOP = 2'd0, RESP = 2'd1, RD = 2'd2, WR = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] addr = '0;
  logic [1:0]  cmd = NOP;
  logic [15:0] data = '0;
  logic [1:0]  cmd_out;
  logic        cmd_oe, data_oe, busy;
  logic [15:0] data_out;

  logic [13:0] addr1 = '0;
  logic [1:0]  cmd1 = NOP;
  logic [15:0] data1 = '0;
  logic [1:0]  cmd_out1;
  logic        cmd_oe1, data_oe1, busy1;
  logic [15:0] data_out1;

  mem_line_server u0 (
    .clk(clk), .reset(reset), .addr_in(addr), .cmd_in(cmd), .data_in(data),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .data_out(data_out), .data_oe(data_oe), .busy(busy)
  );

  mem_line_server #(.LINE_BYTES(2), .BUS_BYTES(2), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .addr_in(addr1), .cmd_in(cmd1), .data_in(data1),
    .cmd_out(cmd_out1), .cmd_oe(cmd_oe1), .data_out(data_out1), .data_oe(data_oe1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] model [256];
  bit           known [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Write a line; the cache samples RESPONSE exactly once, BEATS+LATENCY edges after the command.
  task automatic wr_line(input logic [13:0] a, input logic [127:0] line);
    int t0, resp_edge, resp_cnt, oe_bad;
    t0 = 0; resp_edge = -1; resp_cnt = 0; oe_bad = 0;
    addr = a; cmd = WR;
    for (int i = 0; i < 8; i++) begin
      data = line[16*i +: 16];
      tick();
      if (i == 0) t0 = cyc;
    end
    cmd = NOP; data = '0;
    for (int k = 0; k < 150 && busy; k++) begin
      if (cmd_oe && cmd_out == RESP) begin
        if (resp_edge < 0) resp_edge = cyc + 1;
        resp_cnt++;
      end
      if (data_oe) oe_bad++;
      tick();
    end
    chk("wr_resp_edge", 128'(resp_edge), 128'(t0 + 108));
    chk("wr_resp_cycles", 128'(resp_cnt), 128'(1));
    chk("wr_data_oe_low", 128'(oe_bad), 128'(0));
    chk("wr_idle_after", {127'd0, busy}, 128'(0));
    model[a[7:0]] = line;
    known[a[7:0]] = 1'b1;
  endtask

  // Read a line; optionally present a WRITE_LINE to another address while the read is pending.
  task automatic rd_line(input logic [13:0] a, input bit inject, input logic [13:0] ia,
                         input logic [127:0] iline, output logic [127:0] line);
    int t0, first, nb, oe_bad;
    line = '0; first = -1; nb = 0; oe_bad = 0;
    addr = a; cmd = RD;
    tick();
    t0 = cyc;
    cmd = NOP;
    for (int k = 0; k < 150 && busy; k++) begin
      if (cmd_oe && data_oe && cmd_out == RESP) begin
        if (first < 0) first = cyc + 1;
        if (nb < 8) line[16*nb +: 16] = data_out;
        nb++;
      end
      if (cmd_oe != data_oe) oe_bad++;
      if (inject && k >= 5 && k < 13) begin
        cmd = WR; addr = ia; data = iline[16*(k-5) +: 16];
      end else begin
        cmd = NOP;
      end
      tick();
    end
    cmd = NOP;
    chk("rd_first_beat_edge", 128'(first), 128'(t0 + 101));
    chk("rd_beat_count", 128'(nb), 128'(8));
    chk("rd_end_edge", 128'(cyc), 128'(t0 + 108));
    chk("rd_oe_release", {126'd0, cmd_oe, data_oe}, 128'(0));
    chk("rd_data_out_zero", 128'(data_out), 128'(0));
    chk("rd_oe_together", 128'(oe_bad), 128'(0));
  endtask

  initial begin
    logic [127:0] rline, l155, aline, l020, l5;
    logic [13:0]  pool [8];

    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_low_outputs", {108'd0, cmd_out, cmd_oe, data_oe, busy, data_out}, 128'(0));
    chk("rst_low_outputs_u1", {108'd0, cmd_out1, cmd_oe1, data_oe1, busy1, data_out1}, 128'(0));
    reset = 1'b1;
    tick();
    chk("rst_released_outputs", {108'd0, cmd_out, cmd_oe, data_oe, busy, data_out}, 128'(0));

    // Write then read, known beat pattern 0011, 2233, ... EEFF
    for (int i = 0; i < 8; i++) l155[16*i +: 16] = {8'(2*i*17), 8'((2*i+1)*17)};
    wr_line(14'h0155, l155);
    rd_line(14'h0155, 1'b0, '0, '0, rline);
    chk("rd_0155_data", rline, l155);
    chk("rd_0155_beat0", 128'(rline[15:0]), 128'(16'h0011));

    // Address wrap onto the low index bits
    aline = {8{16'hAAAA}};
    wr_line(14'h0003, aline);
    rd_line(14'h0103, 1'b0, '0, '0, rline);
    chk("wrap_0103", rline, model[8'h03]);

    // Commands while busy are dropped and read timing is unaffected
    l020 = {32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h4B5A6978};
    wr_line(14'h0020, l020);
    rd_line(14'h0155, 1'b1, 14'h0020, {8{16'hDEAD}}, rline);
    chk("busy_rd_data", rline, model[8'h55]);
    rd_line(14'h0020, 1'b0, '0, '0, rline);
    chk("busy_write_dropped", rline, model[8'h20]);

    // Reset mid-write: target line stays fully old
    l5 = {8{16'h5555}};
    wr_line(14'h0040, l5);
    addr = 14'h0040; cmd = WR;
    for (int i = 0; i < 4; i++) begin
      data = 16'h1234 + 16'(i);
      tick();
    end
    reset = 1'b0;
    #1;
    chk("rst_mid_write_outputs", {108'd0, cmd_out, cmd_oe, data_oe, busy, data_out}, 128'(0));
    cmd = NOP; data = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    rd_line(14'h0040, 1'b0, '0, '0, rline);
    chk("rst_mid_write_no_tear", rline, model[8'h40]);

    // Reset mid-RD_WAIT clears outputs within the same cycle
    addr = 14'h0155; cmd = RD;
    tick();
    cmd = NOP;
    repeat (20) tick();
    chk("rd_wait_busy", {127'd0, busy}, 128'(1));
    reset = 1'b0;
    #1;
    chk("rst_mid_read_outputs", {108'd0, cmd_out, cmd_oe, data_oe, busy, data_out}, 128'(0));
    tick();
    reset = 1'b1;
    tick();

    // Randomized writes/reads against the line-level model
    for (int i = 0; i < 8; i++) pool[i] = 14'($urandom_range(0, 16383));
    for (int n = 0; n < 12; n++) begin
      logic [13:0] a;
      a = pool[$urandom_range(0, 7)];
      if (known[a[7:0]] && $urandom_range(0, 1) == 1) begin
        rd_line(a, 1'b0, '0, '0, rline);
        chk("rand_read", rline, model[a[7:0]]);
      end else begin
        wr_line(a, {$urandom, $urandom, $urandom, $urandom});
      end
    end

    // One-beat, one-cycle-latency instance
    cmd1 = WR; addr1 = 14'h0042; data1 = 16'hBEEF;
    tick();
    cmd1 = NOP; data1 = '0;
    chk("min_wr_no_resp_t1", {126'd0, cmd_oe1, data_oe1}, 128'(0));
    tick();
    chk("min_wr_resp_t2", {124'd0, cmd_out1, cmd_oe1, data_oe1}, {124'd0, RESP, 1'b1, 1'b0});
    tick();
    chk("min_wr_done", {126'd0, cmd_oe1, busy1}, 128'(0));
    cmd1 = RD; addr1 = 14'h0142;
    tick();
    cmd1 = NOP;
    chk("min_rd_no_resp_t1", {126'd0, cmd_oe1, data_oe1}, 128'(0));
    tick();
    chk("min_rd_resp_t2", {108'd0, cmd_out1, cmd_oe1, data_oe1, data_out1},
        {108'd0, RESP, 1'b1, 1'b1, 16'hBEEF});
    tick();
    chk("min_rd_done", {109'd0, cmd_oe1, data_oe1, busy1, data_out1}, 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
